// File: rtl/card_shoe_pkg.sv
// Shared types, deck constants and the slot-index decode for the card shoe.
package card_pkg;

  typedef logic [3:0] rank_t;
  typedef logic [1:0] suit_t;

  localparam int DECK_SIZE  = 52;
  localparam int RANK_COUNT = 13;

  localparam rank_t RANK_A = 4'd1;
  localparam rank_t RANK_J = 4'd11;
  localparam rank_t RANK_Q = 4'd12;
  localparam rank_t RANK_K = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHUFFLE,
    ST_SEARCH,
    ST_PRESENT
  } shoe_state_t;

  typedef struct packed {
    rank_t rank;
    suit_t suit;
  } card_t;

  // Slot idx maps to rank idx%13+1 and suit idx/13; compare chain avoids a divider.
  function automatic card_t decode_idx(input logic [5:0] idx);
    card_t c;
    if (idx < 6'(RANK_COUNT)) begin
      c.suit = 2'd0;
      c.rank = rank_t'(idx + 6'd1);
    end else if (idx < 6'(2 * RANK_COUNT)) begin
      c.suit = 2'd1;
      c.rank = rank_t'(idx - 6'(RANK_COUNT - 1));
    end else if (idx < 6'(3 * RANK_COUNT)) begin
      c.suit = 2'd2;
      c.rank = rank_t'(idx - 6'(2 * RANK_COUNT - 1));
    end else begin
      c.suit = 2'd3;
      c.rank = rank_t'(idx - 6'(3 * RANK_COUNT - 1));
    end
    return c;
  endfunction

endpackage

// File: rtl/card_shoe_if.sv
// Request/response bundle between the round controller (master) and the shoe (slave).
interface card_shoe_if;
  import card_pkg::*;

  logic       deal_req;
  logic       new_shoe;
  logic       card_valid;
  rank_t      card;
  suit_t      suit;
  logic       busy;
  logic [5:0] cards_left;
  logic       shoe_empty;

  modport master (
    output deal_req, new_shoe,
    input  card_valid, card, suit, busy, cards_left, shoe_empty
  );

  modport slave (
    input  deal_req, new_shoe,
    output card_valid, card, suit, busy, cards_left, shoe_empty
  );
endinterface

// File: rtl/card_shoe_lfsr.sv
// Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, right-shifting.
module shoe_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign state_o = lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/card_shoe.sv
// Single-deck shoe dealing without replacement; auto-reshuffles when exhausted.
// CARD_SHOE_SEQ_EN: start every search at slot 0 for a deterministic deal order.
//
// state   | meaning
// IDLE    | waiting for deal_req / new_shoe
// SHUFFLE | one cycle after the deck was returned to the shoe
// SEARCH  | probing slots from idx for an undealt card
// PRESENT | card_valid strobe, card/suit hold the dealt card
module card_shoe
  import card_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  card_shoe_if.slave  bus
);

  shoe_state_t state_q, state_d;
  logic [51:0] used_q, used_d;
  logic [5:0]  idx_q, idx_d;
  logic [5:0]  left_q, left_d;
  rank_t       card_q, card_d;
  suit_t       suit_q, suit_d;
  logic        auto_q, auto_d;

  logic [15:0] lfsr;
  logic [5:0]  start_idx;
  logic        lfsr_unused;
  card_t       dec;

  shoe_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (CLOCK_50),
    .rst     (rst),
    .state_o (lfsr)
  );

`ifdef CARD_SHOE_SEQ_EN
  assign start_idx   = '0;
  assign lfsr_unused = ^lfsr;
`else
  assign start_idx   = (lfsr[5:0] >= 6'(DECK_SIZE)) ? lfsr[5:0] - 6'(DECK_SIZE) : lfsr[5:0];
  assign lfsr_unused = ^lfsr[15:6];
`endif

  assign dec = decode_idx(idx_q);

  // The deck is refilled on the edge into SHUFFLE so cards_left reads 52 during it.
  always_comb begin
    state_d = state_q;
    used_d  = used_q;
    idx_d   = idx_q;
    left_d  = left_q;
    card_d  = card_q;
    suit_d  = suit_q;
    auto_d  = auto_q;
    if (bus.new_shoe) begin
      state_d = ST_SHUFFLE;
      auto_d  = 1'b0;
      used_d  = '0;
      left_d  = 6'(DECK_SIZE);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.deal_req) begin
            if (left_q == '0) begin
              state_d = ST_SHUFFLE;
              auto_d  = 1'b1;
              used_d  = '0;
              left_d  = 6'(DECK_SIZE);
            end else begin
              state_d = ST_SEARCH;
              idx_d   = start_idx;
            end
          end
        end
        ST_SHUFFLE: begin
          if (auto_q) begin
            state_d = ST_SEARCH;
            idx_d   = start_idx;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SEARCH: begin
          if (!used_q[idx_q]) begin
            used_d[idx_q] = 1'b1;
            left_d        = left_q - 6'd1;
            card_d        = dec.rank;
            suit_d        = dec.suit;
            state_d       = ST_PRESENT;
          end else begin
            idx_d = (idx_q == 6'(DECK_SIZE - 1)) ? '0 : idx_q + 6'd1;
          end
        end
        ST_PRESENT: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q <= ST_IDLE;
      used_q  <= '0;
      idx_q   <= '0;
      left_q  <= 6'(DECK_SIZE);
      card_q  <= '0;
      suit_q  <= '0;
      auto_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      used_q  <= used_d;
      idx_q   <= idx_d;
      left_q  <= left_d;
      card_q  <= card_d;
      suit_q  <= suit_d;
      auto_q  <= auto_d;
    end
  end

  assign bus.card_valid = (state_q == ST_PRESENT);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.card       = card_q;
  assign bus.suit       = suit_q;
  assign bus.cards_left = left_q;
  assign bus.shoe_empty = (left_q == '0);

endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for card_shoe with an independent LFSR/deck model predicting every deal.
module tb_card_shoe;
  import card_pkg::*;

  logic CLOCK_50 = 1'b0;
  logic rst      = 1'b1;
  int   n_tests  = 0;
  int   n_fail   = 0;

  card_shoe_if bus();

  card_shoe #(.SEED(16'hACE1)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  logic [15:0] m_lfsr;
  bit          m_used [52];
  int          m_left;
  bit          seen   [52];

  always @(posedge CLOCK_50) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_refill();
    for (int i = 0; i < 52; i++) m_used[i] = 1'b0;
    m_left = 52;
  endtask

  // Model of one search starting from LFSR value l; returns slot and skip count.
  function automatic int pick(input logic [15:0] l, output int k);
    int idx;
`ifdef CARD_SHOE_SEQ_EN
    idx = 0;
`else
    idx = int'(l[5:0]);
    if (idx >= 52) idx -= 52;
`endif
    k = 0;
    while (m_used[idx] && k < 52) begin
      idx = (idx == 51) ? 0 : idx + 1;
      k++;
    end
    m_used[idx] = 1'b1;
    m_left--;
    return idx;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic deal(input string tag, output int lat);
    logic [15:0] l;
    int k, idx, extra, oidx;
    extra = 0;
    l = m_lfsr;
    if (m_left == 0) begin
      extra = 1;
      l = lfsr_step(m_lfsr);
      model_refill();
    end
    idx = pick(l, k);
    bus.deal_req = 1'b1;
    lat = 0;
    do begin
      @(negedge CLOCK_50);
      lat++;
      if (lat == 1) bus.deal_req = 1'b0;
    end while (!bus.card_valid && lat < 60);
    check({tag, "_lat"},   lat,            2 + extra + k);
    check({tag, "_card"},  bus.card,       idx % 13 + 1);
    check({tag, "_suit"},  bus.suit,       idx / 13);
    check({tag, "_left"},  bus.cards_left, m_left);
    check({tag, "_empty"}, bus.shoe_empty, (m_left == 0));
    oidx = int'(bus.suit) * 13 + int'(bus.card) - 1;
    if (oidx >= 0 && oidx < 52) seen[oidx] = 1'b1;
    @(negedge CLOCK_50);
    check({tag, "_oneshot"}, bus.card_valid, 1'b0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nseen, k, idx, c, nexp, j;
    int ecyc [8];
    int eidx [8];
    logic [15:0] l;
    bit want;

    bus.deal_req = 1'b0;
    bus.new_shoe = 1'b0;
    model_refill();
    for (int i = 0; i < 52; i++) seen[i] = 1'b0;

    repeat (3) @(negedge CLOCK_50);
    rst = 1'b0;
    check("rst_left",  bus.cards_left, 52);
    check("rst_card",  bus.card,       0);
    check("rst_suit",  bus.suit,       0);
    check("rst_busy",  bus.busy,       0);
    check("rst_valid", bus.card_valid, 0);
    check("rst_empty", bus.shoe_empty, 0);
    check("rst_lfsr",  dut.u_lfsr.state_o, 16'hACE1);

    // Deal out the whole shoe.
    for (int n = 0; n < 52; n++) deal($sformatf("deal%0d", n), lat);
    check("full_left",  bus.cards_left, 0);
    check("full_empty", bus.shoe_empty, 1);
    nseen = 0;
    for (int i = 0; i < 52; i++) nseen += int'(seen[i]);
    check("perm_count", nseen, 52);

    // Exhausted shoe: auto-reshuffle adds one cycle and the fresh deck never skips.
    deal("reshuf", lat);
    check("reshuf_lat3",  lat,            3);
    check("reshuf_left",  bus.cards_left, 51);
`ifdef CARD_SHOE_SEQ_EN
    check("reshuf_ace",   bus.card,       RANK_A);
`endif

    // new_shoe wins over a simultaneous deal_req.
    bus.deal_req = 1'b1;
    bus.new_shoe = 1'b1;
    @(negedge CLOCK_50);
    bus.deal_req = 1'b0;
    bus.new_shoe = 1'b0;
    model_refill();
    check("ns_left",   bus.cards_left, 52);
    check("ns_busy1",  bus.busy,       1);
    check("ns_valid1", bus.card_valid, 0);
    @(negedge CLOCK_50);
    check("ns_busy2",  bus.busy,       0);
    check("ns_valid2", bus.card_valid, 0);
    repeat (3) begin
      @(negedge CLOCK_50);
      check("ns_quiet", bus.card_valid, 0);
    end

    // new_shoe while SEARCH is active aborts the deal.
    bus.deal_req = 1'b1;
    @(negedge CLOCK_50);
    bus.deal_req = 1'b0;
    check("ab_busy0", bus.busy, 1);
    bus.new_shoe = 1'b1;
    @(negedge CLOCK_50);
    bus.new_shoe = 1'b0;
    model_refill();
    check("ab_left",   bus.cards_left, 52);
    check("ab_busy1",  bus.busy,       1);
    check("ab_valid1", bus.card_valid, 0);
    @(negedge CLOCK_50);
    check("ab_busy2",  bus.busy,       0);
    check("ab_valid2", bus.card_valid, 0);

    // deal_req held for 10 cycles: plan acceptances cycle by cycle from the model.
    l = m_lfsr;
    c = 0;
    nexp = 0;
    for (int t = 0; t < 10; t++) begin
      if (t == c) begin
        idx = pick(l, k);
        ecyc[nexp] = c + 2 + k;
        eidx[nexp] = idx;
        nexp++;
        c = c + 3 + k;
      end
      l = lfsr_step(l);
    end
    bus.deal_req = 1'b1;
    j = 0;
    for (int t = 0; t < 30; t++) begin
      if (t == 10) bus.deal_req = 1'b0;
      want = (j < nexp) && (ecyc[j] == t);
      check($sformatf("hold_valid_c%0d", t), bus.card_valid, want);
      if (want) begin
        check($sformatf("hold_card%0d", j), bus.card, eidx[j] % 13 + 1);
        check($sformatf("hold_suit%0d", j), bus.suit, eidx[j] / 13);
        j++;
      end
      @(negedge CLOCK_50);
    end
    check("hold_count", j, nexp);
    check("hold_left",  bus.cards_left, m_left);
    check("hold_busy",  bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
